shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_core.sv | 24 ++
 rtl/shift_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the two-requester shift arbiter.
// Holds op encodings, width defaults and the response FSM states.
package shift_pkg;

    localparam int XLEN_DEF = 64;
    localparam int SHW_DEF  = 6;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/shift_core.sv
// Shared combinational shifter: SRL, SLL, SRA on an XLEN-bit operand.
// The reserved encoding behaves as a logical right shift.
module shift_core
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = SHW_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  n,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = a >> n;
        case (op)
            OP_SLL:  result = a << n;
            OP_SRA:  result = $unsigned($signed(a) >>> n);
            default: result = a >> n;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shared shifter with a single-entry
// result register; a held result can be consumed and replaced in one cycle.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = SHW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [SHW-1:0]  req0_n,
    input  logic [1:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [SHW-1:0]  req1_n,
    input  logic [1:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_id
);

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_id_q, rsp_id_d;

    logic            can_grant;
    logic            gnt0, gnt1, accept;
    logic [XLEN-1:0] sh_a, sh_res;
    logic [SHW-1:0]  sh_n;
    logic [1:0]      sh_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    // Grants stay low while reset is asserted, independent of the clock.
    always_comb begin
        can_grant = rst_n && ((state_q == ST_IDLE) || rsp_ready);
        gnt0 = can_grant && req0_valid && (!req1_valid || !rr_ptr_q);
        gnt1 = can_grant && req1_valid && (!req0_valid || rr_ptr_q);
        accept = gnt0 || gnt1;
    end

    always_comb begin
        sh_a  = req0_a;
        sh_n  = req0_n;
        sh_op = req0_op;
        if (gnt1) begin
            sh_a  = req1_a;
            sh_n  = req1_n;
            sh_op = req1_op;
        end
    end

    shift_core #(
        .XLEN(XLEN),
        .SHW (SHW)
    ) u_core (
        .a     (sh_a),
        .n     (sh_n),
        .op    (sh_op),
        .result(sh_res)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (rsp_ready && !accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Pointer moves to the loser so the other side wins next contention.
        if (accept) begin
            rr_ptr_d   = gnt0;
            rsp_data_d = sh_res;
            rsp_id_d   = gnt1;
        end
    end

    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        rsp_valid  = (state_q == ST_FULL);
        rsp_data   = rsp_data_q;
        rsp_id     = rsp_id_q;
    end

endmodule
